// File: rtl/conv_layer_sched.sv
// Sequencer for the CONV layer-0 / layer-1 flow: 3x3 zero-padded window fetch per pixel,
// L0 result write-back, then 2x2 max-pooling of L0 into L1 over the shared layer-memory port.
module conv_layer_sched #(
    parameter int IMG_LOG2 = 6,
    parameter int DATA_W   = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    output logic                  busy,
    output logic [2*IMG_LOG2-1:0] iaddr,
    output logic                  tap_vld,
    output logic [3:0]            tap_idx,
    output logic                  tap_pad,
    output logic                  acc_clr,
    input  logic                  res_vld,
    input  logic [DATA_W-1:0]     res_data,
    output logic                  crd,
    output logic [2*IMG_LOG2-1:0] caddr_rd,
    input  logic [DATA_W-1:0]     cdata_rd,
    output logic                  cwr,
    output logic [2*IMG_LOG2-1:0] caddr_wr,
    output logic [DATA_W-1:0]     cdata_wr,
    output logic [2:0]            csel
);

    localparam int N  = IMG_LOG2;
    localparam int AW = 2 * IMG_LOG2;
    localparam int BW = 2 * IMG_LOG2 - 2;

    typedef enum logic [2:0] {
        IDLE, L0_FETCH, L0_WAIT, L0_WR, L1_RD, L1_CAP, L1_WR, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       pix_q, pix_d;
    logic [3:0]          k_q, k_d;
    logic [BW-1:0]       blk_q, blk_d;
    logic [1:0]          rd_cnt_q, rd_cnt_d;
    logic                pend_vld_q, pend_vld_d;
    logic [3:0]          pend_idx_q, pend_idx_d;
    logic                pend_pad_q, pend_pad_d;
    logic                rd_first_q, rd_first_d;
    logic                dvld_q, dvld_d;
    logic                dfirst_q, dfirst_d;
    logic [DATA_W-1:0]   max_q, max_d;

    logic                busy_q, busy_d;
    logic [AW-1:0]       iaddr_q, iaddr_d;
    logic                tap_vld_q, tap_vld_d;
    logic [3:0]          tap_idx_q, tap_idx_d;
    logic                tap_pad_q, tap_pad_d;
    logic                acc_clr_q, acc_clr_d;
    logic                crd_q, crd_d;
    logic [AW-1:0]       caddr_rd_q, caddr_rd_d;
    logic                cwr_q, cwr_d;
    logic [AW-1:0]       caddr_wr_q, caddr_wr_d;
    logic [DATA_W-1:0]   cdata_wr_q, cdata_wr_d;
    logic [2:0]          csel_q, csel_d;

    logic [N-1:0]        x, y, tap_x, tap_y;
    logic [1:0]          row, col;
    logic [3:0]          row3;
    logic                pad_x, pad_y, tap_out;

    // Window geometry for the current tap: row/col offsets are k/3 and k%3, shifted by -1.
    always_comb begin
        x       = pix_q[N-1:0];
        y       = pix_q[AW-1:N];
        row     = (k_q >= 4'd6) ? 2'd2 : ((k_q >= 4'd3) ? 2'd1 : 2'd0);
        row3    = {1'b0, row, 1'b0} + {2'b00, row};
        col     = 2'(k_q - row3);
        tap_x   = x + N'(col) - N'(1);
        tap_y   = y + N'(row) - N'(1);
        pad_x   = (col == 2'd0 && x == '0) || (col == 2'd2 && (&x));
        pad_y   = (row == 2'd0 && y == '0) || (row == 2'd2 && (&y));
        tap_out = pad_x || pad_y;
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        k_d        = k_q;
        blk_d      = blk_q;
        rd_cnt_d   = rd_cnt_q;
        busy_d     = busy_q;
        iaddr_d    = iaddr_q;
        pend_vld_d = 1'b0;
        pend_idx_d = '0;
        pend_pad_d = 1'b0;
        tap_vld_d  = pend_vld_q;
        tap_idx_d  = pend_vld_q ? pend_idx_q : 4'd0;
        tap_pad_d  = pend_vld_q & pend_pad_q;
        acc_clr_d  = pend_vld_q && (pend_idx_q == 4'd0);
        crd_d      = 1'b0;
        caddr_rd_d = caddr_rd_q;
        rd_first_d = 1'b0;
        cwr_d      = 1'b0;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = 3'b000;
        dvld_d     = crd_q;
        dfirst_d   = rd_first_q;
        max_d      = max_q;

        // Read data trails crd by one cycle; the first word of a block reloads the max.
        if (dvld_q && (dfirst_q || cdata_rd > max_q)) begin
            max_d = cdata_rd;
        end

        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    busy_d  = 1'b1;
                    pix_d   = '0;
                    k_d     = 4'd0;
                    state_d = L0_FETCH;
                end
            end
            L0_FETCH: begin
                iaddr_d    = tap_out ? '0 : {tap_y, tap_x};
                pend_vld_d = 1'b1;
                pend_idx_d = k_q;
                pend_pad_d = tap_out;
                if (k_q == 4'd8) begin
                    state_d = L0_WAIT;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            L0_WAIT: begin
                if (res_vld && !pend_vld_q) begin
                    cwr_d      = 1'b1;
                    csel_d     = 3'b001;
                    caddr_wr_d = pix_q;
                    cdata_wr_d = res_data;
                    state_d    = L0_WR;
                end
            end
            L0_WR: begin
                pix_d = pix_q + AW'(1);
                k_d   = 4'd0;
                if (&pix_q) begin
                    blk_d    = '0;
                    rd_cnt_d = 2'd0;
                    state_d  = L1_RD;
                end else begin
                    state_d = L0_FETCH;
                end
            end
            L1_RD: begin
                crd_d      = 1'b1;
                csel_d     = 3'b001;
                caddr_rd_d = {blk_q[BW-1:N-1], rd_cnt_q[1], blk_q[N-2:0], rd_cnt_q[0]};
                rd_first_d = (rd_cnt_q == 2'd0);
                rd_cnt_d   = rd_cnt_q + 2'd1;
                if (rd_cnt_q == 2'd3) begin
                    state_d = L1_CAP;
                end
            end
            L1_CAP: begin
                state_d = L1_WR;
            end
            L1_WR: begin
                cwr_d      = 1'b1;
                csel_d     = 3'b011;
                caddr_wr_d = AW'(blk_q);
                cdata_wr_d = max_d;
                blk_d      = blk_q + BW'(1);
                rd_cnt_d   = 2'd0;
                state_d    = (&blk_q) ? DONE : L1_RD;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            k_q        <= '0;
            blk_q      <= '0;
            rd_cnt_q   <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_pad_q <= 1'b0;
            rd_first_q <= 1'b0;
            dvld_q     <= 1'b0;
            dfirst_q   <= 1'b0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            iaddr_q    <= '0;
            tap_vld_q  <= 1'b0;
            tap_idx_q  <= '0;
            tap_pad_q  <= 1'b0;
            acc_clr_q  <= 1'b0;
            crd_q      <= 1'b0;
            caddr_rd_q <= '0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            k_q        <= k_d;
            blk_q      <= blk_d;
            rd_cnt_q   <= rd_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            pend_pad_q <= pend_pad_d;
            rd_first_q <= rd_first_d;
            dvld_q     <= dvld_d;
            dfirst_q   <= dfirst_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            iaddr_q    <= iaddr_d;
            tap_vld_q  <= tap_vld_d;
            tap_idx_q  <= tap_idx_d;
            tap_pad_q  <= tap_pad_d;
            acc_clr_q  <= acc_clr_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign iaddr    = iaddr_q;
    assign tap_vld  = tap_vld_q;
    assign tap_idx  = tap_idx_q;
    assign tap_pad  = tap_pad_q;
    assign acc_clr  = acc_clr_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: stub MAC, layer-memory model and an event-order reference model
// derived from the image/window/pooling arithmetic.
module tb_conv_layer_sched;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic        tap_vld;
    logic [3:0]  tap_idx;
    logic        tap_pad;
    logic        acc_clr;
    logic        res_vld;
    logic [19:0] res_data;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    logic [68:0] all_outs;
    logic [19:0] res_tab [4096];
    logic [19:0] l0_mem [4096];
    int          vec_count;
    int          miscompares;
    int          stub_pix;
    int          stub_delay;

    conv_layer_sched #(.IMG_LOG2(6), .DATA_W(20)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
        .tap_vld(tap_vld), .tap_idx(tap_idx), .tap_pad(tap_pad), .acc_clr(acc_clr),
        .res_vld(res_vld), .res_data(res_data), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .csel(csel)
    );

    assign all_outs = {busy, iaddr, tap_vld, tap_idx, tap_pad, acc_clr, crd, caddr_rd,
                       cwr, caddr_wr, cdata_wr, csel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub MAC: answers three cycles after tap 8 with the next value from res_tab.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            res_vld    = 1'b0;
            res_data   = 20'd0;
            stub_delay = 0;
            stub_pix   = 0;
        end else begin
            res_vld = 1'b0;
            if (stub_delay > 0) begin
                stub_delay--;
                if (stub_delay == 0) begin
                    res_vld  = 1'b1;
                    res_data = res_tab[stub_pix % 4096];
                    stub_pix++;
                end
            end
            if (tap_vld && tap_idx == 4'd8) stub_delay = 3;
        end
    end

    always @(posedge clk) begin
        if (cwr && csel == 3'b001) l0_mem[caddr_wr] <= cdata_wr;
        if (crd) cdata_rd <= l0_mem[caddr_rd];
    end

    task automatic test_reset;
        reset = 1'b0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_count++;
        if (all_outs !== 69'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: outputs %h, expected 0", all_outs);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vec_count++;
            if (all_outs !== 69'd0) begin
                miscompares++;
                $display("[TB] FAIL idle_after_reset cycle %0d: outputs %h, expected 0", i, all_outs);
            end
        end
    endtask

    task automatic test_origin_and_abort;
        logic [11:0] prev_iaddr;
        logic [11:0] cap_addr [9];
        logic        cap_pad [9];
        int          exp_addr [9];
        logic        exp_pad [9];
        logic        got_wr;
        logic [11:0] wr_addr;
        logic [19:0] wr_data;
        logic [2:0]  wr_sel;
        int          taps;
        bit          hit;
        exp_addr = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
        exp_pad  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        res_tab[0] = 20'h00123;
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        vec_count++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_rise: got %b, expected 1", busy);
        end
        taps = 0; hit = 0; got_wr = 0;
        wr_addr = '0; wr_data = '0; wr_sel = '0;
        prev_iaddr = iaddr;
        for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
            @(negedge clk);
            if (tap_vld) begin
                if (taps < 9) begin
                    cap_addr[taps] = prev_iaddr;
                    cap_pad[taps]  = tap_pad;
                end
                taps++;
            end
            if (cwr && !got_wr) begin
                got_wr = 1; wr_addr = caddr_wr; wr_data = cdata_wr; wr_sel = csel;
            end
            if (taps == 901) hit = 1;
            prev_iaddr = iaddr;
        end
        vec_count++;
        if (!hit) begin
            miscompares++;
            $display("[TB] FAIL pixel100_timeout: taps seen %0d, expected 901", taps);
        end
        reset = 1'b0;
        #1;
        vec_count++;
        if (all_outs !== 69'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_reset: outputs %h, expected 0", all_outs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 9; k++) begin
            vec_count++;
            if (cap_addr[k] !== 12'(exp_addr[k]) || cap_pad[k] !== exp_pad[k]) begin
                miscompares++;
                $display("[TB] FAIL origin_tap%0d: iaddr %0d pad %b, expected iaddr %0d pad %b",
                         k, cap_addr[k], cap_pad[k], exp_addr[k], exp_pad[k]);
            end
        end
        vec_count++;
        if (!got_wr || wr_addr !== 12'd0 || wr_data !== 20'h00123 || wr_sel !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL origin_write: seen %b addr %0d data %h csel %b, expected addr 0 data 00123 csel 001",
                     got_wr, wr_addr, wr_data, wr_sel);
        end
    endtask

    task automatic test_full_run;
        int          l0_cnt, l1_cnt, tap_seen, rd_seen, busy_falls, post;
        int          p, k, nx, ny, b, base, j, exp_a;
        logic        exp_p, prev_busy;
        logic [11:0] prev_iaddr;
        logic [19:0] m;
        logic [11:0] last_addr [9];
        logic        last_pad [9];
        int          last_exp_addr [9];
        logic        last_exp_pad [9];
        logic [11:0] b0_rd [4];
        logic [11:0] bl_rd [4];
        int          b0_exp [4];
        int          bl_exp [4];
        logic [11:0] b0_wa, bl_wa;
        logic [19:0] b0_wd;
        logic [2:0]  b0_ws;
        last_exp_addr = '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0};
        last_exp_pad  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        b0_exp = '{0, 1, 64, 65};
        bl_exp = '{4030, 4031, 4094, 4095};
        b0_wa = '0; bl_wa = '0; b0_wd = '0; b0_ws = '0;
        res_tab[0] = 20'd5; res_tab[1] = 20'd9; res_tab[64] = 20'd3; res_tab[65] = 20'd7;
        l0_cnt = 0; l1_cnt = 0; tap_seen = 0; rd_seen = 0; busy_falls = 0; post = 0;
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        prev_busy  = busy;
        prev_iaddr = iaddr;
        for (int cyc = 0; cyc < 75000 && post < 20; cyc++) begin
            @(negedge clk);
            vec_count++;
            if (crd && cwr) begin
                miscompares++;
                $display("[TB] FAIL crd_cwr_overlap: crd %b cwr %b, expected not both", crd, cwr);
            end
            if (!crd && !cwr) begin
                vec_count++;
                if (csel !== 3'b000) begin
                    miscompares++;
                    $display("[TB] FAIL csel_idle: got %b, expected 000", csel);
                end
            end
            if (tap_vld) begin
                p = tap_seen / 9; k = tap_seen % 9;
                nx = p % 64 + k % 3 - 1; ny = p / 64 + k / 3 - 1;
                exp_p = (nx < 0 || nx > 63 || ny < 0 || ny > 63);
                exp_a = exp_p ? 0 : ny * 64 + nx;
                vec_count++;
                if (tap_idx !== 4'(k) || tap_pad !== exp_p || prev_iaddr !== 12'(exp_a)
                    || acc_clr !== (k == 0)) begin
                    miscompares++;
                    $display("[TB] FAIL tap p%0d k%0d: idx %0d pad %b iaddr %0d clr %b, expected idx %0d pad %b iaddr %0d clr %b",
                             p, k, tap_idx, tap_pad, prev_iaddr, acc_clr, k, exp_p, exp_a, k == 0);
                end
                if (p == 4095) begin
                    last_addr[k] = prev_iaddr; last_pad[k] = tap_pad;
                end
                tap_seen++;
            end else begin
                vec_count++;
                if (acc_clr !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL acc_clr_alone: got %b, expected 0", acc_clr);
                end
            end
            if (crd) begin
                b = rd_seen / 4; j = rd_seen % 4;
                exp_a = (b / 32) * 128 + (b % 32) * 2 + (j % 2) + (j / 2) * 64;
                vec_count++;
                if (caddr_rd !== 12'(exp_a) || csel !== 3'b001 || l0_cnt != 4096) begin
                    miscompares++;
                    $display("[TB] FAIL l1_read %0d: addr %0d csel %b l0 writes %0d, expected addr %0d csel 001 l0 writes 4096",
                             rd_seen, caddr_rd, csel, l0_cnt, exp_a);
                end
                if (b == 0) b0_rd[j] = caddr_rd;
                if (b == 1023) bl_rd[j] = caddr_rd;
                rd_seen++;
            end
            if (cwr) begin
                vec_count++;
                if (l0_cnt < 4096) begin
                    if (caddr_wr !== 12'(l0_cnt) || cdata_wr !== res_tab[l0_cnt] || csel !== 3'b001) begin
                        miscompares++;
                        $display("[TB] FAIL l0_write %0d: addr %0d data %h csel %b, expected addr %0d data %h csel 001",
                                 l0_cnt, caddr_wr, cdata_wr, csel, l0_cnt, res_tab[l0_cnt]);
                    end
                    l0_cnt++;
                end else if (l1_cnt < 1024) begin
                    b = l1_cnt;
                    base = (b / 32) * 128 + (b % 32) * 2;
                    m = res_tab[base];
                    if (res_tab[base + 1] > m) m = res_tab[base + 1];
                    if (res_tab[base + 64] > m) m = res_tab[base + 64];
                    if (res_tab[base + 65] > m) m = res_tab[base + 65];
                    if (caddr_wr !== 12'(b) || cdata_wr !== m || csel !== 3'b011 || rd_seen != 4 * (b + 1)) begin
                        miscompares++;
                        $display("[TB] FAIL l1_write %0d: addr %0d data %h csel %b reads %0d, expected addr %0d data %h csel 011 reads %0d",
                                 b, caddr_wr, cdata_wr, csel, rd_seen, b, m, 4 * (b + 1));
                    end
                    if (b == 0) begin b0_wa = caddr_wr; b0_wd = cdata_wr; b0_ws = csel; end
                    if (b == 1023) bl_wa = caddr_wr;
                    l1_cnt++;
                end else begin
                    miscompares++;
                    $display("[TB] FAIL extra_write: addr %0d, expected no write", caddr_wr);
                end
            end
            if (prev_busy && !busy) busy_falls++;
            if (busy_falls > 0) post++;
            prev_busy  = busy;
            prev_iaddr = iaddr;
        end
        vec_count++;
        if (busy_falls != 1 || l0_cnt != 4096 || l1_cnt != 1024 || tap_seen != 36864 || rd_seen != 4096) begin
            miscompares++;
            $display("[TB] FAIL run_totals: falls %0d l0 %0d l1 %0d taps %0d reads %0d, expected 1 4096 1024 36864 4096",
                     busy_falls, l0_cnt, l1_cnt, tap_seen, rd_seen);
        end
        for (int t = 0; t < 9; t++) begin
            vec_count++;
            if (last_addr[t] !== 12'(last_exp_addr[t]) || last_pad[t] !== last_exp_pad[t]) begin
                miscompares++;
                $display("[TB] FAIL corner_tap%0d: iaddr %0d pad %b, expected iaddr %0d pad %b",
                         t, last_addr[t], last_pad[t], last_exp_addr[t], last_exp_pad[t]);
            end
        end
        for (int t = 0; t < 4; t++) begin
            vec_count++;
            if (b0_rd[t] !== 12'(b0_exp[t]) || bl_rd[t] !== 12'(bl_exp[t])) begin
                miscompares++;
                $display("[TB] FAIL block_reads %0d: first %0d last %0d, expected %0d %0d",
                         t, b0_rd[t], bl_rd[t], b0_exp[t], bl_exp[t]);
            end
        end
        vec_count++;
        if (b0_wa !== 12'd0 || b0_wd !== 20'd9 || b0_ws !== 3'b011 || bl_wa !== 12'd1023) begin
            miscompares++;
            $display("[TB] FAIL block_writes: first addr %0d data %0d csel %b last addr %0d, expected 0 9 011 1023",
                     b0_wa, b0_wd, b0_ws, bl_wa);
        end
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        reset       = 1'b0;
        ready       = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            res_tab[i] = 20'($urandom);
            l0_mem[i]  = 20'd0;
        end
        test_reset();
        test_origin_and_abort();
        test_full_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
